// File: rtl/alu_bist_engine.sv
// rtl/alu_bist_engine.sv - LFSR stimulus / MISR response BIST engine for the 2-bit alu wrapper
module alu_bist_engine #(
  parameter int         NPATTERNS     = 31,
  parameter int         SETTLE_CYCLES = 1,
  parameter logic [4:0] SEED          = 5'b00001,
  parameter logic [7:0] GOLDEN_SIG    = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [4:0] pi_out,
  input  logic [1:0] po_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] signature,
  output logic [7:0] pat_cnt
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_APPLY   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  // An all-zero seed would lock the LFSR, so it is promoted to 1.
  localparam logic [4:0] SEED_EFF    = (SEED == 5'b0) ? 5'b00001 : SEED;
  localparam logic [7:0] LAST_PAT    = 8'(NPATTERNS - 1);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES);

  logic [1:0] state;
  logic [4:0] lfsr;
  logic [3:0] settle_cnt;
  logic [4:0] lfsr_next;
  logic [7:0] misr_next;

  assign lfsr_next = {lfsr[3:0], lfsr[4] ^ lfsr[2]};
  assign misr_next = {signature[6:0], 1'b0} ^ (signature[7] ? 8'h1D : 8'h00) ^ {6'b0, po_in};

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      lfsr       <= SEED_EFF;
      settle_cnt <= 4'd0;
      pi_out     <= 5'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      signature  <= 8'h00;
      pat_cnt    <= 8'd0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            lfsr       <= SEED_EFF;
            signature  <= 8'h00;
            pat_cnt    <= 8'd0;
            settle_cnt <= 4'd0;
            pi_out     <= SEED_EFF;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            state      <= S_APPLY;
          end
        end
        S_APPLY: begin
          if (settle_cnt == SETTLE_LAST) begin
            state <= S_CAPTURE;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        S_CAPTURE: begin
          signature  <= misr_next;
          lfsr       <= lfsr_next;
          settle_cnt <= 4'd0;
          if (pat_cnt == LAST_PAT) begin
            state  <= S_DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            pass   <= (misr_next == GOLDEN_SIG);
            pi_out <= 5'b0;
          end else begin
            // The pattern bus only moves when a fresh pattern enters APPLY.
            pat_cnt <= pat_cnt + 8'd1;
            pi_out  <= lfsr_next;
            state   <= S_APPLY;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_bist_engine.sv
// tb/tb_alu_bist_engine.sv - self-checking bench for alu_bist_engine
module tb_alu_bist_engine;

  function automatic logic [1:0] alu_model(input logic [4:0] p);
    logic [1:0] a, b;
    a = p[4:3];
    b = p[2:1];
    return p[0] ? (a ^ b) : 2'(a + b);
  endfunction

  // mode 0: constant response, 1: alu response, 2: alu with zout[1] stuck-at-0
  function automatic logic [7:0] model_sig(input int npat, input logic [4:0] seed,
                                           input int mode, input logic [1:0] cval);
    logic [4:0] l;
    logic [7:0] s;
    logic [1:0] z;
    logic [1:0] ab;
    l = (seed == 5'b0) ? 5'b00001 : seed;
    s = 8'h00;
    for (int i = 0; i < npat; i++) begin
      ab = 2'(l[4:3] + l[2:1]);
      if (mode == 0) z = cval;
      else           z = l[0] ? (l[4:3] ^ l[2:1]) : ab;
      if (mode == 2) z[1] = 1'b0;
      s = {s[6:0], 1'b0} ^ (s[7] ? 8'h1D : 8'h00) ^ {6'b0, z};
      l = {l[3:0], l[4] ^ l[2]};
    end
    return s;
  endfunction

  localparam logic [7:0] GOLD_A = model_sig(4, 5'b00001, 0, 2'b10);
  localparam logic [7:0] GOLD_F = model_sig(31, 5'b00001, 1, 2'b00);

  logic clk = 1'b0;
  logic rst;
  logic start_a, start_m, start_f, start_s;
  logic [1:0] po_a, po_m, po_f, po_f2, po_s;
  logic [4:0] pi_a, pi_m, pi_f, pi_f2, pi_s;
  logic busy_a, busy_m, busy_f, busy_f2, busy_s;
  logic done_a, done_m, done_f, done_f2, done_s;
  logic pass_a, pass_m, pass_f, pass_f2, pass_s;
  logic [7:0] sig_a, sig_m, sig_f, sig_f2, sig_s;
  logic [7:0] pc_a, pc_m, pc_f, pc_f2, pc_s;

  always #5 clk = ~clk;

  assign po_f  = alu_model(pi_f);
  assign po_f2 = {1'b0, alu_model(pi_f2)[0]};

  alu_bist_engine #(.NPATTERNS(4), .SETTLE_CYCLES(0), .SEED(5'b00001), .GOLDEN_SIG(GOLD_A)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .pi_out(pi_a), .po_in(po_a), .busy(busy_a),
    .done(done_a), .pass(pass_a), .signature(sig_a), .pat_cnt(pc_a));
  alu_bist_engine #(.NPATTERNS(2), .SETTLE_CYCLES(0), .SEED(5'b00001), .GOLDEN_SIG(8'h03)) u_m (
    .clk(clk), .rst(rst), .start(start_m), .pi_out(pi_m), .po_in(po_m), .busy(busy_m),
    .done(done_m), .pass(pass_m), .signature(sig_m), .pat_cnt(pc_m));
  alu_bist_engine #(.NPATTERNS(31), .SETTLE_CYCLES(1), .SEED(5'b00001), .GOLDEN_SIG(GOLD_F)) u_f (
    .clk(clk), .rst(rst), .start(start_f), .pi_out(pi_f), .po_in(po_f), .busy(busy_f),
    .done(done_f), .pass(pass_f), .signature(sig_f), .pat_cnt(pc_f));
  alu_bist_engine #(.NPATTERNS(31), .SETTLE_CYCLES(1), .SEED(5'b00001), .GOLDEN_SIG(GOLD_F)) u_f2 (
    .clk(clk), .rst(rst), .start(start_f), .pi_out(pi_f2), .po_in(po_f2), .busy(busy_f2),
    .done(done_f2), .pass(pass_f2), .signature(sig_f2), .pat_cnt(pc_f2));
  alu_bist_engine #(.NPATTERNS(3), .SETTLE_CYCLES(3), .SEED(5'b00000), .GOLDEN_SIG(8'h0F)) u_s (
    .clk(clk), .rst(rst), .start(start_s), .pi_out(pi_s), .po_in(po_s), .busy(busy_s),
    .done(done_s), .pass(pass_s), .signature(sig_s), .pat_cnt(pc_s));

  typedef struct {
    logic [1:0] po;
    logic [7:0] sig1;
    logic [7:0] sig2;
    logic       pass;
  } misr_vec_t;

  misr_vec_t    mt[4];
  logic [4:0]   lseq[4];
  logic [1:0]   cap_val[3];
  logic [31:0]  exp_q[$];
  int           n_checks = 0;
  int           n_fail = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs engine A once; start is re-pulsed on cycle busy_pulse (-1 = never).
  task automatic run_a(input string tag, input int busy_pulse);
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    chk({tag, "_done_clr"}, 32'(done_a), 32'd0);
    chk({tag, "_pass_clr"}, 32'(pass_a), 32'd0);
    for (int k = 0; k < 8; k++) exp_q.push_back(32'(lseq[k / 2]));
    for (int k = 0; k < 8; k++) begin
      chk({tag, "_pi"}, 32'(pi_a), exp_q.pop_front());
      chk({tag, "_pat_cnt"}, 32'(pc_a), 32'(k / 2));
      chk({tag, "_busy"}, 32'(busy_a), 32'd1);
      chk({tag, "_done_low"}, 32'(done_a), 32'd0);
      start_a = (k == busy_pulse);
      step();
      start_a = 1'b0;
    end
    chk({tag, "_done"}, 32'(done_a), 32'd1);
    chk({tag, "_busy_end"}, 32'(busy_a), 32'd0);
    chk({tag, "_pi_end"}, 32'(pi_a), 32'd0);
    chk({tag, "_sig"}, 32'(sig_a), 32'(GOLD_A));
    chk({tag, "_pass"}, 32'(pass_a), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    mt[0] = '{po: 2'b01, sig1: 8'h01, sig2: 8'h03, pass: 1'b1};
    mt[1] = '{po: 2'b00, sig1: 8'h00, sig2: 8'h00, pass: 1'b0};
    mt[2] = '{po: 2'b10, sig1: 8'h02, sig2: 8'h06, pass: 1'b0};
    mt[3] = '{po: 2'b11, sig1: 8'h03, sig2: 8'h05, pass: 1'b0};
    lseq[0] = 5'b00001; lseq[1] = 5'b00010; lseq[2] = 5'b00100; lseq[3] = 5'b01001;
    cap_val[0] = 2'b10; cap_val[1] = 2'b11; cap_val[2] = 2'b01;

    rst = 1'b1;
    start_a = 1'b0; start_m = 1'b0; start_f = 1'b0; start_s = 1'b0;
    po_a = 2'b10; po_m = 2'b00; po_s = 2'b00;
    step();
    step();
    rst = 1'b0;
    step();
    chk("rst_pi", 32'(pi_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_sig", 32'(sig_a), 32'd0);

    run_a("lfsr", -1);
    run_a("restart", -1);
    run_a("busy_start", 3);

    // Reset in the middle of a pattern
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("midrst_pi", 32'(pi_a), 32'd0);
    chk("midrst_busy", 32'(busy_a), 32'd0);
    chk("midrst_done", 32'(done_a), 32'd0);
    chk("midrst_pass", 32'(pass_a), 32'd0);
    chk("midrst_sig", 32'(sig_a), 32'd0);
    chk("midrst_pat_cnt", 32'(pc_a), 32'd0);
    step();
    chk("midrst_idle", 32'(busy_a), 32'd0);

    run_a("after_rst", -1);
    rst = 1'b1;
    start_a = 1'b1;
    step();
    rst = 1'b0;
    start_a = 1'b0;
    chk("rststart_done", 32'(done_a), 32'd0);
    chk("rststart_busy", 32'(busy_a), 32'd0);
    chk("rststart_pass", 32'(pass_a), 32'd0);
    step();
    chk("rststart_idle", 32'(busy_a), 32'd0);
    chk("rststart_pi", 32'(pi_a), 32'd0);

    // Constant-response MISR vectors
    for (int i = 0; i < 4; i++) begin
      po_m = mt[i].po;
      start_m = 1'b1;
      step();
      start_m = 1'b0;
      step();
      step();
      chk("misr_sig1", 32'(sig_m), 32'(mt[i].sig1));
      step();
      step();
      chk("misr_sig2", 32'(sig_m), 32'(mt[i].sig2));
      chk("misr_done", 32'(done_m), 32'd1);
      chk("misr_pass", 32'(pass_m), 32'(mt[i].pass));
    end

    // Full run against the alu model, good and stuck-at-0 response
    begin
      int cyc;
      start_f = 1'b1;
      step();
      start_f = 1'b0;
      cyc = 0;
      while (!done_f && cyc < 200) begin
        step();
        cyc++;
      end
      chk("full_len", 32'(cyc), 32'd93);
      chk("full_sig", 32'(sig_f), 32'(GOLD_F));
      chk("full_pass", 32'(pass_f), 32'd1);
      chk("stuck_done", 32'(done_f2), 32'd1);
      chk("stuck_sig", 32'(sig_f2), 32'(model_sig(31, 5'b00001, 2, 2'b00)));
      chk("stuck_pass", 32'(pass_f2), 32'd0);
    end

    // Settle window: only the capture-cycle response reaches the signature
    start_s = 1'b1;
    step();
    start_s = 1'b0;
    for (int c = 0; c < 15; c++) exp_q.push_back(32'(lseq[c / 5]));
    for (int c = 0; c < 15; c++) begin
      chk("settle_pi", 32'(pi_s), exp_q.pop_front());
      chk("settle_done_low", 32'(done_s), 32'd0);
      po_s = (c % 5 == 4) ? cap_val[c / 5] : 2'($urandom_range(0, 3));
      step();
    end
    chk("settle_done", 32'(done_s), 32'd1);
    chk("settle_sig", 32'(sig_s), 32'h0F);
    chk("settle_pass", 32'(pass_s), 32'd1);
    chk("settle_pat_cnt", 32'(pc_s), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
